// File: rtl/bp_be_stride_pf_sched.sv
// Stride prefetch scheduler: keeps a small table of strided-load streams trained by the RPT
// and issues their prefetch addresses round-robin to one valid/ready D$ prefetch port.
module bp_be_stride_pf_sched #(
    parameter int vaddr_width_p       = 39,
    parameter int stride_width_p      = 8,
    parameter int streams_p           = 4,
    parameter int depth_p             = 4,
    parameter int page_offset_width_p = 12
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      enable_i,
    input  logic                      init_done_i,
    input  logic                      stride_v_i,
    input  logic [vaddr_width_p-1:0]  pc_i,
    input  logic [vaddr_width_p-1:0]  eff_addr_i,
    input  logic [stride_width_p-1:0] stride_i,
    input  logic                      flush_i,
    output logic                      pf_v_o,
    output logic [vaddr_width_p-1:0]  pf_addr_o,
    input  logic                      pf_ready_i,
    output logic                      busy_o
);
    localparam int IW = $clog2(streams_p);
    localparam int PW = vaddr_width_p - page_offset_width_p;

    // Handshake: pf_v_o/pf_addr_o are registered; a request transfers on any edge where
    // pf_v_o & pf_ready_i, and the address is held stable until then (only flush drops it).

    logic [streams_p-1:0]     r_v;
    logic [vaddr_width_p-1:0] r_pc     [streams_p];
    logic [PW-1:0]            r_page   [streams_p];
    logic [vaddr_width_p-1:0] r_next   [streams_p];
    logic [vaddr_width_p-1:0] r_stride [streams_p];
    logic [3:0]               r_rem    [streams_p];
    logic [IW-1:0]            r_rr;
    logic [IW-1:0]            r_victim;
    logic                     r_pf_v;
    logic [vaddr_width_p-1:0] r_pf_addr;

    logic [vaddr_width_p-1:0] w_stride_sext;
    logic                     w_train;
    logic                     w_hit;
    logic [IW-1:0]            w_hit_idx;
    logic                     w_free;
    logic [IW-1:0]            w_free_idx;
    logic [IW-1:0]            w_train_idx;
    logic [streams_p-1:0]     w_live;
    logic [streams_p-1:0]     w_elig;
    logic                     w_pick_v;
    logic [IW-1:0]            w_pick_idx;
    logic                     w_load;
    logic                     w_issue_go;
    logic                     w_same_page;

    assign w_stride_sext = {{(vaddr_width_p-stride_width_p){stride_i[stride_width_p-1]}}, stride_i};
    assign w_train = stride_v_i & init_done_i & enable_i & ~flush_i & (stride_i != '0);

    // Lowest index wins for both searches: scan downward and let later matches overwrite.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_idx  = '0;
        w_free     = 1'b0;
        w_free_idx = '0;
        for (int i = streams_p - 1; i >= 0; i--) begin
            if (r_v[i] && (r_pc[i] == pc_i)) begin
                w_hit     = 1'b1;
                w_hit_idx = IW'(i);
            end
            if (!r_v[i]) begin
                w_free     = 1'b1;
                w_free_idx = IW'(i);
            end
        end
    end

    assign w_train_idx = w_hit ? w_hit_idx : (w_free ? w_free_idx : r_victim);

    always_comb begin
        w_live = '0;
        w_elig = '0;
        for (int i = 0; i < streams_p; i++) begin
            w_live[i] = r_v[i] & (r_rem[i] != 4'd0);
            w_elig[i] = w_live[i] & ~(w_train & (w_train_idx == IW'(i)));
        end
    end

    // Round-robin: first eligible stream at or after r_rr.
    always_comb begin
        logic [IW-1:0] cand;
        w_pick_v   = 1'b0;
        w_pick_idx = '0;
        cand       = '0;
        for (int k = streams_p - 1; k >= 0; k--) begin
            cand = r_rr + IW'(k);
            if (w_elig[cand]) begin
                w_pick_v   = 1'b1;
                w_pick_idx = cand;
            end
        end
    end

    assign w_load      = enable_i & (~r_pf_v | pf_ready_i);
    assign w_issue_go  = w_load & w_pick_v;
    assign w_same_page = (r_next[w_pick_idx][vaddr_width_p-1:page_offset_width_p] == r_page[w_pick_idx]);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_v       <= '0;
            r_rr      <= '0;
            r_victim  <= '0;
            r_pf_v    <= 1'b0;
            r_pf_addr <= '0;
            for (int i = 0; i < streams_p; i++) begin
                r_pc[i]     <= '0;
                r_page[i]   <= '0;
                r_next[i]   <= '0;
                r_stride[i] <= '0;
                r_rem[i]    <= '0;
            end
        end else if (flush_i) begin
            r_v      <= '0;
            r_rr     <= '0;
            r_victim <= '0;
            r_pf_v   <= 1'b0;
            for (int i = 0; i < streams_p; i++) begin
                r_rem[i] <= '0;
            end
        end else begin
            if (r_pf_v && pf_ready_i) begin
                r_pf_v <= 1'b0;
            end
            // Training never targets the picked entry, so both updates can land in one edge.
            if (w_issue_go) begin
                r_rr <= w_pick_idx + IW'(1);
                if (w_same_page) begin
                    r_pf_v               <= 1'b1;
                    r_pf_addr            <= r_next[w_pick_idx];
                    r_next[w_pick_idx]   <= r_next[w_pick_idx] + r_stride[w_pick_idx];
                    r_rem[w_pick_idx]    <= r_rem[w_pick_idx] - 4'd1;
                end else begin
                    r_rem[w_pick_idx] <= '0;
                end
            end
            if (w_train) begin
                r_v[w_train_idx]      <= 1'b1;
                r_pc[w_train_idx]     <= pc_i;
                r_page[w_train_idx]   <= eff_addr_i[vaddr_width_p-1:page_offset_width_p];
                r_next[w_train_idx]   <= eff_addr_i + w_stride_sext;
                r_stride[w_train_idx] <= w_stride_sext;
                r_rem[w_train_idx]    <= 4'(depth_p);
                if (!w_hit && !w_free) begin
                    r_victim <= r_victim + IW'(1);
                end
            end
        end
    end

    assign pf_v_o    = r_pf_v;
    assign pf_addr_o = r_pf_addr;
    assign busy_o    = r_pf_v | (|w_live);

endmodule

// File: tb/tb_bp_be_stride_pf_sched.sv
// Bench for bp_be_stride_pf_sched: directed vector table, hand-written corner sequences,
// and randomized traffic checked every cycle against a stream-level reference model.
module tb_bp_be_stride_pf_sched;
    localparam int VA    = 39;
    localparam int SW    = 8;
    localparam int NS    = 4;
    localparam int DEPTH = 4;
    localparam int PO    = 12;
    localparam longint unsigned MASK = (64'd1 << VA) - 64'd1;

    // ---------------- clock / reset / DUT ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic          enable;
    logic          init_done;
    logic          stride_v;
    logic [VA-1:0] pc;
    logic [VA-1:0] eff_addr;
    logic [SW-1:0] stride;
    logic          flush;
    logic          pf_v;
    logic [VA-1:0] pf_addr;
    logic          pf_ready;
    logic          busy;

    bp_be_stride_pf_sched #(
        .vaddr_width_p(VA), .stride_width_p(SW), .streams_p(NS),
        .depth_p(DEPTH), .page_offset_width_p(PO)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n), .enable_i(enable), .init_done_i(init_done),
        .stride_v_i(stride_v), .pc_i(pc), .eff_addr_i(eff_addr), .stride_i(stride),
        .flush_i(flush), .pf_v_o(pf_v), .pf_addr_o(pf_addr), .pf_ready_i(pf_ready),
        .busy_o(busy)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model (stream table in plain integers) ----------------
    bit              m_v    [NS];
    longint unsigned m_pc   [NS];
    longint unsigned m_page [NS];
    longint unsigned m_next [NS];
    longint unsigned m_str  [NS];
    int              m_rem  [NS];
    int              m_rr;
    int              m_victim;
    bit              m_pfv;
    longint unsigned m_pfaddr;

    function automatic longint unsigned sext(input logic [SW-1:0] s);
        longint v;
        v = longint'($signed(s));
        return longint'(v) & MASK;
    endfunction

    function automatic bit model_busy();
        bit b;
        b = m_pfv;
        for (int i = 0; i < NS; i++) if (m_v[i] && m_rem[i] > 0) b = 1'b1;
        return b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            m_v[i] = 0; m_pc[i] = 0; m_page[i] = 0; m_next[i] = 0; m_str[i] = 0; m_rem[i] = 0;
        end
        m_rr = 0; m_victim = 0; m_pfv = 0; m_pfaddr = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        bit trn, hit, free;
        int tidx, pick;
        longint unsigned e;
        if (flush) begin
            for (int i = 0; i < NS; i++) begin m_v[i] = 0; m_rem[i] = 0; end
            m_pfv = 0; m_rr = 0; m_victim = 0;
            return;
        end
        trn = stride_v && init_done && enable && (stride != 0);
        e = 64'(eff_addr);
        hit = 0; free = 0; tidx = -1;
        if (trn) begin
            for (int i = 0; i < NS; i++) if (m_v[i] && m_pc[i] == 64'(pc)) begin hit = 1; tidx = i; end
            if (!hit) for (int i = NS - 1; i >= 0; i--) if (!m_v[i]) begin free = 1; tidx = i; end
            if (!hit && !free) tidx = m_victim;
        end
        if (m_pfv && pf_ready) m_pfv = 0;
        if (enable && !m_pfv) begin
            pick = -1;
            for (int k = 0; k < NS; k++) begin
                int j;
                j = (m_rr + k) % NS;
                if (pick < 0 && m_v[j] && m_rem[j] > 0 && j != tidx) pick = j;
            end
            if (pick >= 0) begin
                m_rr = (pick + 1) % NS;
                if ((m_next[pick] >> PO) == m_page[pick]) begin
                    m_pfv = 1;
                    m_pfaddr = m_next[pick];
                    m_next[pick] = (m_next[pick] + m_str[pick]) & MASK;
                    m_rem[pick]--;
                end else begin
                    m_rem[pick] = 0;
                end
            end
        end
        if (trn) begin
            m_v[tidx] = 1; m_pc[tidx] = 64'(pc); m_page[tidx] = e >> PO;
            m_next[tidx] = (e + sext(stride)) & MASK; m_str[tidx] = sext(stride);
            m_rem[tidx] = DEPTH;
            if (!hit && !free) m_victim = (m_victim + 1) % NS;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("mdl_v", 64'(pf_v), 64'(m_pfv));
        if (m_pfv) chk("mdl_addr", 64'(pf_addr), m_pfaddr);
        chk("mdl_busy", 64'(busy), 64'(model_busy()));
    endtask

    task automatic idle();
        stride_v = 0; pc = '0; eff_addr = '0; stride = '0;
    endtask

    task automatic train(input logic [VA-1:0] p, input logic [VA-1:0] e, input logic [SW-1:0] s);
        stride_v = 1; pc = p; eff_addr = e; stride = s;
    endtask

    task automatic do_flush();
        idle(); flush = 1; tick(); flush = 0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic          sv;
        logic [VA-1:0] pc;
        logic [VA-1:0] eff;
        logic [SW-1:0] st;
        logic          rdy;
        logic          ev;
        logic [VA-1:0] ea;
        logic          eb;
    } vec_t;
    vec_t vecs[$];

    task automatic add_vec(input logic sv, input logic [VA-1:0] p, input logic [VA-1:0] e,
                           input logic [SW-1:0] s, input logic rdy, input logic ev,
                           input logic [VA-1:0] ea, input logic eb);
        vec_t v;
        v.sv = sv; v.pc = p; v.eff = e; v.st = s; v.rdy = rdy; v.ev = ev; v.ea = ea; v.eb = eb;
        vecs.push_back(v);
    endtask

    // ---------------- scoreboard ----------------
    logic [VA-1:0] exp_q[$];

    task automatic sb_observe(input string name);
        if (pf_v) begin
            if (exp_q.size() == 0) begin
                chk({name, "_extra"}, 64'(pf_addr), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                chk(name, 64'(pf_addr), 64'(exp_q.pop_front()));
            end
        end
    endtask

    initial begin
        logic [VA-1:0] e;
        // single stream, then the same stream with backpressure
        add_vec(1, 39'h100, 39'h8000, 8'h40, 1, 0, 39'h0,    1);
        add_vec(0, 39'h0,   39'h0,    8'h00, 1, 1, 39'h8040, 1);
        add_vec(0, 39'h0,   39'h0,    8'h00, 1, 1, 39'h8080, 1);
        add_vec(0, 39'h0,   39'h0,    8'h00, 1, 1, 39'h80C0, 1);
        add_vec(0, 39'h0,   39'h0,    8'h00, 1, 1, 39'h8100, 1);
        add_vec(0, 39'h0,   39'h0,    8'h00, 1, 0, 39'h0,    0);
        add_vec(1, 39'h100, 39'h8000, 8'h40, 1, 0, 39'h0,    1);
        add_vec(0, 39'h0,   39'h0,    8'h00, 1, 1, 39'h8040, 1);
        add_vec(0, 39'h0,   39'h0,    8'h00, 0, 1, 39'h8040, 1);
        add_vec(0, 39'h0,   39'h0,    8'h00, 0, 1, 39'h8040, 1);
        add_vec(0, 39'h0,   39'h0,    8'h00, 0, 1, 39'h8040, 1);
        add_vec(0, 39'h0,   39'h0,    8'h00, 1, 1, 39'h8080, 1);
        add_vec(0, 39'h0,   39'h0,    8'h00, 1, 1, 39'h80C0, 1);
        add_vec(0, 39'h0,   39'h0,    8'h00, 1, 1, 39'h8100, 1);
        add_vec(0, 39'h0,   39'h0,    8'h00, 1, 0, 39'h0,    0);

        // reset state
        reset_n = 0; enable = 1; init_done = 1; flush = 0; pf_ready = 1; idle();
        model_reset();
        #1;
        chk("rst_v", 64'(pf_v), 64'd0);
        chk("rst_addr", 64'(pf_addr), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("post_rst_idle_v", 64'(pf_v), 64'd0);
        end

        // table-driven directed vectors
        for (int i = 0; i < vecs.size(); i++) begin
            stride_v = vecs[i].sv; pc = vecs[i].pc; eff_addr = vecs[i].eff;
            stride = vecs[i].st; pf_ready = vecs[i].rdy;
            tick();
            chk($sformatf("vec%0d_v", i), 64'(pf_v), 64'(vecs[i].ev));
            if (vecs[i].ev) chk($sformatf("vec%0d_addr", i), 64'(pf_addr), 64'(vecs[i].ea));
            chk($sformatf("vec%0d_busy", i), 64'(busy), 64'(vecs[i].eb));
        end

        // page cross with negative stride
        pf_ready = 1;
        do_flush();
        train(39'h300, 39'h9010, 8'hF0); tick();
        chk("pg_t0_v", 64'(pf_v), 64'd0);
        idle(); tick();
        chk("pg_t1_v", 64'(pf_v), 64'd1);
        chk("pg_t1_addr", 64'(pf_addr), 64'h9000);
        tick();
        chk("pg_t2_v", 64'(pf_v), 64'd0);
        chk("pg_t2_busy", 64'(busy), 64'd0);
        tick();
        chk("pg_t3_v", 64'(pf_v), 64'd0);

        // round-robin between two streams, then retrain A mid-flight
        do_flush();
        exp_q = {39'h8040, 39'hA008, 39'h8080, 39'hA010, 39'hA018,
                 39'h8240, 39'hA020, 39'h8280, 39'h82C0, 39'h8300};
        for (int c = 0; c < 16; c++) begin
            idle();
            if (c == 0) train(39'h100, 39'h8000, 8'h40);
            if (c == 1) train(39'h200, 39'hA000, 8'h08);
            if (c == 5) train(39'h100, 39'h8200, 8'h40);
            tick();
            sb_observe("rr_addr");
        end
        chk("rr_left", 64'(exp_q.size()), 64'd0);
        chk("rr_busy", 64'(busy), 64'd0);

        // fill all four entries, drain, then two new PCs evict entries in victim order
        do_flush();
        for (int c = 0; c < 4; c++) begin
            train(39'(64'h10 * (c + 1)), 39'(64'h10000 * (c + 1)), 8'h08); tick();
        end
        idle();
        repeat (24) tick();
        chk("ev_drained_busy", 64'(busy), 64'd0);
        exp_q = {39'h50008, 39'h60008, 39'h50010, 39'h60010,
                 39'h50018, 39'h60018, 39'h50020, 39'h60020};
        for (int c = 0; c < 12; c++) begin
            idle();
            if (c == 0) train(39'h50, 39'h50000, 8'h08);
            if (c == 1) train(39'h60, 39'h60000, 8'h08);
            tick();
            sb_observe("ev_addr");
        end
        chk("ev_left", 64'(exp_q.size()), 64'd0);

        // flush while a request is held under backpressure
        do_flush();
        pf_ready = 0;
        train(39'h100, 39'h8000, 8'h40); tick();
        idle(); tick(); tick();
        chk("fl_held_v", 64'(pf_v), 64'd1);
        chk("fl_held_addr", 64'(pf_addr), 64'h8040);
        flush = 1; tick(); flush = 0;
        chk("fl_v", 64'(pf_v), 64'd0);
        chk("fl_busy", 64'(busy), 64'd0);
        pf_ready = 1; tick(); tick();
        chk("fl_after_v", 64'(pf_v), 64'd0);

        // asynchronous reset mid-stream
        pf_ready = 0;
        train(39'h100, 39'h8000, 8'h40); tick();
        idle(); tick();
        chk("ar_pre_v", 64'(pf_v), 64'd1);
        #2;
        reset_n = 0;
        #1;
        chk("ar_v", 64'(pf_v), 64'd0);
        chk("ar_busy", 64'(busy), 64'd0);
        chk("ar_addr", 64'(pf_addr), 64'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1;
        pf_ready = 1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("ar_idle_v", 64'(pf_v), 64'd0);
        end

        // randomized traffic against the model
        do_flush();
        for (int c = 0; c < 1500; c++) begin
            stride_v  = ($urandom_range(0, 99) < 30);
            pc        = 39'(64'h100 * $urandom_range(1, 6));
            e         = 39'({$urandom(), $urandom()});
            if ($urandom_range(0, 9) == 0) e[VA-1:PO] = '1;
            e[PO-1:0] = ($urandom_range(0, 1) == 1) ? 12'($urandom_range(0, 255))
                                                    : 12'(4095 - $urandom_range(0, 255));
            eff_addr  = e;
            stride    = ($urandom_range(0, 19) == 0) ? 8'h00 : 8'($urandom());
            pf_ready  = ($urandom_range(0, 99) < 70);
            enable    = ($urandom_range(0, 99) < 90);
            init_done = ($urandom_range(0, 99) < 95);
            flush     = ($urandom_range(0, 99) < 2);
            tick();
        end
        flush = 0; enable = 1; init_done = 1; idle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bp_be_stride_pf_sched.md
# bp_be_stride_pf_sched

Stride prefetch scheduler in the backend checker. It consumes stride detections from the reference prediction table (one `{pc, eff_addr, stride}` per strided-load hit) and keeps a small table of active prefetch streams. It issues up to `depth_p` prefetch addresses per stream, choosing among streams round-robin, to the D$ prefetch port over a valid/ready handshake. It shares the single prefetch port between all live streams and stops each stream at its 4 KiB page boundary.

## Interface
- `vaddr_width_p`, 39, virtual address width
- `stride_width_p`, 8, stride width; two's complement, sign-extended to `vaddr_width_p`
- `streams_p`, 4, stream table entries; power of 2, ≥2
- `depth_p`, 4, prefetches issued per training event; 1..15
- `page_offset_width_p`, 12, page offset bits; a prefetch never leaves the trigger's page
- `clk_i`  in  1  clock
- `reset_n_i`  in  1  asynchronous, active-low reset
- `enable_i`  in  1  global prefetch enable
- `init_done_i`  in  1  RPT initialisation complete; training is ignored while low
- `stride_v_i`  in  1  training valid, single-cycle pulse
- `pc_i`  in  `vaddr_width_p`  load PC (stream tag)
- `eff_addr_i`  in  `vaddr_width_p`  trigger effective address
- `stride_i`  in  `stride_width_p`  detected stride
- `flush_i`  in  1  invalidate all streams and any pending prefetch
- `pf_v_o`  out  1  prefetch request valid
- `pf_addr_o`  out  `vaddr_width_p`  prefetch virtual address
- `pf_ready_i`  in  1  D$ accepts request
- `busy_o`  out  1  some stream has remaining > 0, or `pf_v_o` is high

## Operation
- Each stream entry holds: `v`, `pc` (full width), `page` (trigger bits [vaddr-1:page_offset]), `next_addr`, `stride`, `rem` (4 bits).
- Training is accepted when `stride_v_i & init_done_i & enable_i & ~flush_i & stride_i != 0`. A zero stride is silently ignored.
  - **Hit:** some valid entry has `pc == pc_i`. That entry is overwritten with `next_addr = eff_addr_i + sext(stride_i)`, `stride`, `page`, and `rem = depth_p`.
  - **Miss, free entry:** the lowest-index invalid entry is allocated with the same fields.
  - **Miss, table full:** the entry at `victim_r` is replaced, then `victim_r` increments modulo `streams_p`.
- A stream is eligible when `v & rem != 0 & (stream index != trained index this cycle)`. Training always takes precedence over issue for the same entry.
- **Issue:** when `enable_i` is high and the output register is empty or being accepted this cycle, the round-robin arbiter picks the first eligible stream at or after `rr_r`.
  - If the picked stream's `next_addr` page equals its `page`: load `pf_addr_o <= next_addr`, set `pf_v_o <= 1`, `next_addr += sext(stride)`, `rem -= 1`, and `rr_r <= picked + 1`.
  - If the page differs (the stream crossed its page): set `rem <= 0`, issue nothing this cycle, and advance `rr_r` past that stream.
- Address arithmetic wraps modulo 2^`vaddr_width_p`.
- An entry stays valid when `rem` reaches 0, so a later training event with the same PC refreshes it in place.
- **Handshake:** once `pf_v_o` is high, `pf_addr_o` is held stable until `pf_v_o & pf_ready_i`. `pf_v_o` is never withdrawn except by `flush_i`.
- **`enable_i` low:** training is ignored and no new requests are loaded. A request already presented stays presented until accepted.
- **`flush_i`:** at the next edge, clears all `v` and `rem`, clears `pf_v_o`, and resets `rr_r` and `victim_r` to 0. A `flush_i` coinciding with a handshake counts that request as accepted.
- `busy_o` is combinational from registered state.

## Timing
- **Reset values:** all entries invalid; `pf_v_o=0`, `pf_addr_o=0`, `busy_o=0`; `rr_r=0`, `victim_r=0`.
- Training sampled at edge E updates the table at E. The first prefetch is loaded at E+1, so `pf_v_o` is high starting the cycle after E+1: two cycles from the training pulse to the request.
- Throughput is one prefetch per cycle while `pf_ready_i` is held high.
- The asynchronous reset may assert mid-stream: all state returns to reset values immediately, regardless of the clock.

## Test plan
- **Reset:** assert `reset_n_i=0` mid-run → `pf_v_o=0`, `busy_o=0` immediately; after release, no request until a training event.
- **Single stream:** train `pc=0x100`, `eff=0x8000`, `stride=0x40`, `ready=1` → `pf_addr_o` = 0x8040, 0x8080, 0x80C0, 0x8100 on consecutive cycles starting two cycles after training; then `pf_v_o=0`, `busy_o=0`.
- **Backpressure:** same stimulus with `ready=0` for 3 cycles → 0x8040 held stable for 4 cycles; the rest follow back-to-back once ready rises.
- **Page cross with negative stride:** `eff=0x9010`, `stride=0xF0` (−16) → only 0x9000 is issued; 0x8FF0 is suppressed and `rem` is cleared.
- **Round-robin and retrain:** train A (`pc=0x100`, `eff=0x8000`, stride 0x40) and B (`pc=0x200`, `eff=0xA000`, stride 8) → requests interleave 0x8040, 0xA008, 0x8080, 0xA010, …. Retraining A with `eff=0x8200` restarts A at 0x8240 with 4 remaining.
- **Eviction and flush:** train 5 distinct PCs with `streams_p=4` → the 5th replaces entry 0 and `victim_r=1`. Asserting `flush_i` while `pf_v_o=1` and `ready=0` → `pf_v_o=0` next cycle, `busy_o=0`.
